// File: rtl/fp_mult_add_unit.sv
// Non-fused binary32 multiply-add, result = ax + round(ay*az), as a four-stage pipeline.
// Both roundings are round-to-nearest-even; subnormal inputs and results are flushed to zero.
module fp_mult_add_unit (
  input  logic        clk,
  input  logic        aclr,
  input  logic        ena,
  input  logic [31:0] ax,
  input  logic [31:0] ay,
  input  logic [31:0] az,
  output logic [31:0] result
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  function automatic logic [24:0] rne_round(input logic [23:0] m, input logic g, input logic s);
    return {1'b0, m} + {24'd0, g & (s | m[0])};
  endfunction

  // Folds a rounding carry into the exponent, saturates to infinity, flushes underflow to +0.
  function automatic logic [31:0] pack_fp(input logic sgn, input logic signed [10:0] e,
                                          input logic [24:0] m);
    logic signed [10:0] ef;
    logic        [22:0] f;
    ef = m[24] ? e + 11'sd1 : e;
    f  = m[24] ? m[23:1] : m[22:0];
    if (ef >= 11'sd255) return {sgn, 8'hFF, 23'd0};
    if (ef <= 11'sd0)   return 32'h0;
    return {sgn, ef[7:0], f};
  endfunction

  function automatic logic [4:0] lzc27(input logic [26:0] v);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 27; i++)
      if (v[i]) n = 5'(26 - i);
    return n;
  endfunction

  // ---- S1: input registers ----
  logic [31:0] ax_p1, ay_p1, az_p1;

  always_ff @(posedge clk) begin
    if (aclr) begin
      ax_p1 <= '0;
      ay_p1 <= '0;
      az_p1 <= '0;
    end else if (ena) begin
      ax_p1 <= ax;
      ay_p1 <= ay;
      az_p1 <= az;
    end
  end

  // ---- S2: mantissa product, exponent sum, product rounding ----
  logic               y_zero, z_zero, y_inf, z_inf, y_nan, z_nan, p_sgn, p_g, p_s;
  logic        [47:0] p_full;
  logic signed [10:0] p_exp;
  logic        [22:0] p_man;
  logic        [31:0] prod_w;
  logic        [31:0] ax_p2, prod_p2;

  always_comb begin
    y_zero = (ay_p1[30:23] == 8'h00);
    z_zero = (az_p1[30:23] == 8'h00);
    y_inf  = (ay_p1[30:23] == 8'hFF) && (ay_p1[22:0] == 23'd0);
    z_inf  = (az_p1[30:23] == 8'hFF) && (az_p1[22:0] == 23'd0);
    y_nan  = (ay_p1[30:23] == 8'hFF) && (ay_p1[22:0] != 23'd0);
    z_nan  = (az_p1[30:23] == 8'hFF) && (az_p1[22:0] != 23'd0);
    p_sgn  = ay_p1[31] ^ az_p1[31];
    p_full = {24'd0, 1'b1, ay_p1[22:0]} * {24'd0, 1'b1, az_p1[22:0]};
    p_exp  = $signed({3'b000, ay_p1[30:23]}) + $signed({3'b000, az_p1[30:23]}) - 11'sd127;
    if (p_full[47]) begin
      p_man = p_full[46:24];
      p_g   = p_full[23];
      p_s   = |p_full[22:0];
      p_exp = p_exp + 11'sd1;
    end else begin
      p_man = p_full[45:23];
      p_g   = p_full[22];
      p_s   = |p_full[21:0];
    end
    if (y_nan || z_nan || (y_inf && z_zero) || (z_inf && y_zero)) prod_w = QNAN;
    else if (y_inf || z_inf)                                      prod_w = {p_sgn, 8'hFF, 23'd0};
    else if (y_zero || z_zero)                                    prod_w = {p_sgn, 31'd0};
    else prod_w = pack_fp(p_sgn, p_exp, rne_round({1'b1, p_man}, p_g, p_s));
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      ax_p2   <= '0;
      prod_p2 <= '0;
    end else if (ena) begin
      ax_p2   <= ax_p1;
      prod_p2 <= prod_w;
    end
  end

  // ---- S3: exponent compare, alignment with guard/round/sticky, add/subtract ----
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, a_big, eff_sub;
  logic               spec_w, sgn_w;
  logic        [31:0] spec_val_w, big;
  logic        [30:0] small_mag;
  logic        [7:0]  diff;
  logic        [26:0] big_ext, small_ext, small_al;
  logic        [27:0] sum_w;
  logic signed [10:0] exp_w;
  logic               spec_p3, sgn_p3;
  logic        [31:0] spec_val_p3;
  logic signed [10:0] exp_p3;
  logic        [27:0] sum_p3;

  always_comb begin
    a_zero    = (ax_p2[30:23] == 8'h00);
    b_zero    = (prod_p2[30:23] == 8'h00);
    a_inf     = (ax_p2[30:23] == 8'hFF) && (ax_p2[22:0] == 23'd0);
    b_inf     = (prod_p2[30:23] == 8'hFF) && (prod_p2[22:0] == 23'd0);
    a_nan     = (ax_p2[30:23] == 8'hFF) && (ax_p2[22:0] != 23'd0);
    b_nan     = (prod_p2[30:23] == 8'hFF) && (prod_p2[22:0] != 23'd0);
    a_big     = (ax_p2[30:0] >= prod_p2[30:0]);
    big       = a_big ? ax_p2 : prod_p2;
    small_mag = a_big ? prod_p2[30:0] : ax_p2[30:0];
    diff      = big[30:23] - small_mag[30:23];
    big_ext   = {1'b1, big[22:0], 3'b000};
    small_ext = {1'b1, small_mag[22:0], 3'b000};
    if (diff >= 8'd26) small_al = 27'd1;
    else small_al = (small_ext >> diff[4:0])
                  | {26'd0, |(small_ext << (5'd27 - diff[4:0]))};
    eff_sub = ax_p2[31] ^ prod_p2[31];
    sum_w   = eff_sub ? {1'b0, big_ext} - {1'b0, small_al}
                      : {1'b0, big_ext} + {1'b0, small_al};
    sgn_w   = big[31];
    exp_w   = $signed({3'b000, big[30:23]});
    spec_w     = 1'b1;
    spec_val_w = 32'h0;
    if (a_nan || b_nan)      spec_val_w = QNAN;
    else if (a_inf && b_inf) spec_val_w = (ax_p2[31] == prod_p2[31]) ? ax_p2 : QNAN;
    else if (a_inf)          spec_val_w = ax_p2;
    else if (b_inf)          spec_val_w = prod_p2;
    else if (a_zero && b_zero) spec_val_w = {ax_p2[31] & prod_p2[31], 31'd0};
    else if (a_zero)         spec_val_w = prod_p2;
    else if (b_zero)         spec_val_w = ax_p2;
    else                     spec_w     = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (aclr) begin
      spec_p3     <= 1'b0;
      spec_val_p3 <= '0;
      sgn_p3      <= 1'b0;
      exp_p3      <= '0;
      sum_p3      <= '0;
    end else if (ena) begin
      spec_p3     <= spec_w;
      spec_val_p3 <= spec_val_w;
      sgn_p3      <= sgn_w;
      exp_p3      <= exp_w;
      sum_p3      <= sum_w;
    end
  end

  // ---- S4: normalise, round, special-case select, result register ----
  logic        [4:0]  lz;
  logic        [26:0] norm;
  logic signed [10:0] exp4;
  logic        [31:0] res_w;

  always_comb begin
    lz = 5'd0;
    if (sum_p3[27]) begin
      norm = {sum_p3[27:2], sum_p3[1] | sum_p3[0]};
      exp4 = exp_p3 + 11'sd1;
    end else begin
      lz   = lzc27(sum_p3[26:0]);
      norm = sum_p3[26:0] << lz;
      exp4 = exp_p3 - $signed({6'd0, lz});
    end
    if (spec_p3)              res_w = spec_val_p3;
    else if (sum_p3 == 28'd0) res_w = 32'h0;
    else res_w = pack_fp(sgn_p3, exp4, rne_round(norm[26:3], norm[2], norm[1] | norm[0]));
  end

  always_ff @(posedge clk) begin
    if (aclr)     result <= '0;
    else if (ena) result <= res_w;
  end

endmodule

// File: tb/tb_fp_mult_add_unit.sv
// Directed-vector bench for fp_mult_add_unit; expected results are hand-computed binary32 values.
module tb_fp_mult_add_unit;

  logic        clk = 1'b0;
  logic        aclr, ena;
  logic [31:0] ax, ay, az, result;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  fp_mult_add_unit dut (
    .clk(clk), .aclr(aclr), .ena(ena), .ax(ax), .ay(ay), .az(az), .result(result)
  );

  // {ax, ay, az, expected result}
  localparam logic [127:0] DIR [0:22] = '{
    {32'h40000000, 32'h40800000, 32'h41000000, 32'h42080000},  // 2 + 4*8 = 34
    {32'h40000000, 32'h3F800000, 32'hC0000000, 32'h00000000},  // exact cancel -> +0
    {32'h3F800000, 32'h7F800000, 32'h00000000, 32'h7FC00000},  // inf*0
    {32'h00000000, 32'h7F000000, 32'h40000000, 32'h7F800000},  // product overflow
    {32'h3F800000, 32'h00000001, 32'h3F800000, 32'h3F800000},  // subnormal input
    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000},  // 1 + 1*1
    {32'h80000000, 32'h80000000, 32'h3F800000, 32'h80000000},  // -0 + -0
    {32'h7F800000, 32'h7F800000, 32'hBF800000, 32'h7FC00000},  // +inf + -inf
    {32'h7F800000, 32'h3F800000, 32'h3F800000, 32'h7F800000},  // +inf ax
    {32'hFF800000, 32'h3F800000, 32'h3F800000, 32'hFF800000},  // -inf ax
    {32'h3F800000, 32'hFF800000, 32'h40000000, 32'hFF800000},  // -inf product
    {32'h7FA00000, 32'h3F800000, 32'h3F800000, 32'h7FC00000},  // NaN ax
    {32'h3F800000, 32'h7F800001, 32'h3F800000, 32'h7FC00000},  // NaN ay
    {32'h3F800000, 32'h2F000000, 32'h3F800000, 32'h3F800000},  // shift 33 -> sticky only
    {32'h3F7FFFFF, 32'h33000000, 32'h3F800000, 32'h3F800000},  // tie, mantissa carry-out
    {32'h7F7FFFFF, 32'h7F7FFFFF, 32'h3F800000, 32'h7F800000},  // sum overflow
    {32'hBF800002, 32'h3F800001, 32'h3F800001, 32'h00000000},  // two roundings cancel
    {32'h00000000, 32'h3F800001, 32'h3F800001, 32'h3F800002},  // product rounding
    {32'h80000000, 32'h00800000, 32'h3F000000, 32'h00000000},  // product underflow -> +0
    {32'h00800001, 32'h80800000, 32'h3F800000, 32'h00000000},  // sum underflow -> +0
    {32'h40400000, 32'h3F800000, 32'hBFC00000, 32'h3FC00000},  // 3 - 1.5
    {32'h3F800000, 32'hC0000000, 32'h3F800000, 32'hBF800000},  // 1 - 2
    {32'h3F800000, 32'h33C00000, 32'h3F800000, 32'h3F800001}   // above half -> round up
  };

  // A, B, C, D, garbage, zero
  localparam logic [127:0] SEQ [0:5] = '{
    {32'h40000000, 32'h40800000, 32'h41000000, 32'h42080000},
    {32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h40000000},
    {32'h40400000, 32'h3F800000, 32'hBFC00000, 32'h3FC00000},
    {32'h3F800000, 32'hC0000000, 32'h3F800000, 32'hBF800000},
    {32'h3F800000, 32'h40000000, 32'h40400000, 32'h40E00000},
    {32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000}
  };
  localparam int B2B_IN  [0:7]  = '{0, 1, 2, 3, 5, 5, 5, 5};
  localparam int B2B_OUT [0:7]  = '{5, 5, 5, 0, 1, 2, 3, 5};
  localparam int ST_IN   [0:10] = '{0, 1, 2, 3, 4, 4, 4, 5, 5, 5, 5};
  localparam bit ST_EN   [0:10] = '{1, 1, 1, 1, 0, 0, 0, 1, 1, 1, 1};
  localparam int ST_OUT  [0:10] = '{5, 5, 5, 0, 0, 0, 0, 1, 2, 3, 5};

  task automatic drive(input logic e, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] z);
    ena = e; ax = x; ay = y; az = z;
  endtask

  task automatic idle(input int n);
    drive(1'b1, 32'h0, 32'h0, 32'h0);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    aclr = 1'b1;
    drive(1'b0, 32'hDEADBEEF, 32'h12345678, 32'h9ABCDEF0);
    repeat (2) @(negedge clk);
    n_vec++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL reset_state: result=%h expected=%h", result, 32'h0);
    end
    aclr = 1'b0;
    idle(4);
  endtask

  task automatic test_aclr_hold();
    aclr = 1'b1;
    drive(1'b1, 32'h40000000, 32'h40800000, 32'h41000000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_vec++;
      if (result !== 32'h0) begin
        n_err++;
        $display("FAIL aclr_hold[%0d]: result=%h expected=%h", i, result, 32'h0);
      end
    end
    aclr = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      logic [31:0] want;
      @(negedge clk);
      want = (k == 4) ? 32'h42080000 : 32'h0;
      n_vec++;
      if (result !== want) begin
        n_err++;
        $display("FAIL aclr_release[edge %0d]: result=%h expected=%h", k, result, want);
      end
    end
  endtask

  task automatic test_directed();
    logic [127:0] v;
    for (int i = 0; i < 23; i++) begin
      v = DIR[i];
      drive(1'b1, v[127:96], v[95:64], v[63:32]);
      repeat (4) @(negedge clk);
      n_vec++;
      if (result !== v[31:0]) begin
        n_err++;
        $display("FAIL directed[%0d] ax=%h ay=%h az=%h: result=%h expected=%h",
                 i, v[127:96], v[95:64], v[63:32], result, v[31:0]);
      end
    end
    idle(4);
  endtask

  task automatic test_back_to_back();
    logic [127:0] v, w;
    for (int i = 0; i < 8; i++) begin
      v = SEQ[B2B_IN[i]];
      w = SEQ[B2B_OUT[i]];
      drive(1'b1, v[127:96], v[95:64], v[63:32]);
      @(negedge clk);
      n_vec++;
      if (result !== w[31:0]) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: result=%h expected=%h", i, result, w[31:0]);
      end
    end
  endtask

  task automatic test_ena_stall();
    logic [127:0] v, w;
    for (int i = 0; i < 11; i++) begin
      v = SEQ[ST_IN[i]];
      w = SEQ[ST_OUT[i]];
      drive(ST_EN[i], v[127:96], v[95:64], v[63:32]);
      @(negedge clk);
      n_vec++;
      if (result !== w[31:0]) begin
        n_err++;
        $display("FAIL ena_stall[%0d]: result=%h expected=%h", i, result, w[31:0]);
      end
    end
    idle(4);
  endtask

  task automatic test_midop_reset();
    logic [127:0] v;
    for (int i = 0; i < 3; i++) begin
      v = SEQ[i];
      drive(1'b1, v[127:96], v[95:64], v[63:32]);
      @(negedge clk);
    end
    aclr = 1'b1;
    drive(1'b1, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    aclr = 1'b0;
    n_vec++;
    if (result !== 32'h0) begin
      n_err++;
      $display("FAIL midop_reset[flush]: result=%h expected=%h", result, 32'h0);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      n_vec++;
      if (result !== 32'h0) begin
        n_err++;
        $display("FAIL midop_reset[edge %0d]: result=%h expected=%h", k, result, 32'h0);
      end
    end
  endtask

  initial begin
    aclr = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    @(negedge clk);
    test_reset();
    test_aclr_hold();
    test_directed();
    test_back_to_back();
    test_ena_stall();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
